lpm_deserializer: RTL and testbench
===================================

Name: lpm_deserializer

Overview:
- Serial-to-parallel word assembler that sits directly downstream of lpm_shiftreg. It consumes the shiftout bit stream and rebuilds lpm_width-bit words.
- Bit order matches the upstream lpm_direction. The optional frame marker resynchronises word boundaries.
- Completed words are buffered in a 2-entry output queue with a valid/ready handshake, so downstream stalls do not lose bits until the queue is full.

Parameters:
- lpm_width, 8, word width in bits (>=2).
- lpm_direction, "LEFT", "LEFT" = first received bit is MSB (matches upstream LEFT shiftout); "RIGHT" = first bit is LSB; any other value prints an error at elaboration and behaves as "LEFT".
- lpm_type, "lpm_deserializer", identification string.

Ports:
- clock  input  1  rising-edge clock.
- aclr_n  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous clear (tri0); same effect as reset, takes effect at the next edge.
- shiftin  input  1  serial data bit (connect to upstream shiftout).
- shift_en  input  1  qualifies shiftin on this edge (tri1).
- frame  input  1  (tri0) when high with shift_en, the current bit is bit 0 of a new word.
- q  output  lpm_width  head-of-queue word.
- q_valid  output  1  q holds a valid word.
- q_ready  input  1  consumer accepts q this cycle.
- bit_count  output  ceil(log2(lpm_width))  bits collected in the current partial word.
- overrun  output  1  sticky: a completed word was dropped because the queue was full.
- frame_err  output  1  sticky: frame arrived while a partial word was in progress.

Behaviour:
- Reset (aclr_n low, async) and sclr (sync) have the same effect:
  - bit_count=0, accumulator=0, queue empty.
  - q_valid=0, q=0, overrun=0, frame_err=0.
  - sclr has priority over all other activity in its cycle.
- Accumulation happens only on edges with shift_en=1.
  - LEFT: acc <= {acc[w-2:0], shiftin}.
  - RIGHT: acc <= {shiftin, acc[w-1:1]}.
  - shift_en=0: acc and bit_count hold.
- Frame:
  - frame=1 with shift_en=1 forces this bit into position 0 of a fresh word. The partial word is discarded and bit_count becomes 1.
  - If bit_count was nonzero, frame_err is set.
  - frame without shift_en is ignored.
- Completion: the edge where shift_en=1 and bit_count=w-1 (or w=... via frame restart, never) pushes the assembled word, including this bit, into the queue. bit_count wraps to 0 on the same edge.
- Latency: the last bit is sampled at edge N; q_valid=1 and q=word are visible after edge N, i.e. in cycle N+1.
- Queue: 2 entries, in-order.
  - Pop occurs when q_valid and q_ready are both high at an edge.
  - A push and a pop on the same edge are both performed, including when the queue is full, so no overrun in that case.
  - A push when the queue is full with no pop: the word is dropped, the queue is unchanged, and overrun is set.
  - q_ready with q_valid=0 is ignored.
  - q is held stable while q_valid=1 and q_ready=0.
  - q=0 when empty.
- Sticky flags clear only on reset or sclr.
- Reset mid-word discards the partial word. Reset with a full queue discards both entries.

Decomposition:
- Package lpm_deser_pkg: constants DIR_LEFT/DIR_RIGHT, queue depth constant QDEPTH=2, a function clog2 for bit_count width.
- One sub-module is natural: lpm_deser_queue, a 2-entry register FIFO. It has push/pop/data/full/empty, handles simultaneous push and pop when full, and is reused by the later serializer.
- Bit assembly, counter and flags stay in the top module.

Test Plan:
- w=8 LEFT, stream 1,0,1,0,0,1,1,0 with shift_en=1 and q_ready=1 -> q=8'hA6, q_valid for 1 cycle, exactly 1 cycle after the 8th bit; bit_count returns to 0.
- w=8 RIGHT, same stream -> q=8'h65; back-to-back words 8'h01 and 8'hFF -> q_valid high 2 cycles, order preserved.
- q_ready=0, send 3 words (0x11, 0x22, 0x33) -> q=0x11 held, 0x33 dropped, overrun=1; then q_ready=1 -> 0x11, 0x22 emitted, q_valid falls.
- Queue full, q_ready=1 on the same edge a 4th word completes -> no overrun; outputs 0x11, 0x22, new word in order.
- After 3 bits, assert frame with shift_en=1, then 7 more bits (0xC3 total, MSB first) -> frame_err=1, q=0xC3; shift_en gaps of 1-5 cycles mid-word -> same result.
- aclr_n pulsed low asynchronously mid-word with 1 queued word -> q_valid=0, bit_count=0, flags 0 immediately; sclr=1 during a completion edge -> no push, all cleared.

Source files
------------

// File: rtl/lpm_deser_pkg.sv
// Shared constants and helpers for the LPM deserializer and its output queue.
package lpm_deser_pkg;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";
  localparam int    QDEPTH    = 2;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lpm_deser_queue.sv
// Small in-order register FIFO; head is always entry 0 and reads as zero when empty.
// A push and a pop on the same edge are both honoured, even when the queue is full.
module lpm_deser_queue
  import lpm_deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = QDEPTH
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [CW-1:0]    count, count_nxt, wr_idx;
  logic             do_pop, do_push;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_nxt   = mem;
    count_nxt = count;
    do_pop    = pop && (count != '0);
    do_push   = push && ((count != CW'(DEPTH)) || do_pop);
    wr_idx    = do_pop ? count - CW'(1) : count;

    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
      mem_nxt[DEPTH-1] = '0;
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == CW'(i)) mem_nxt[i] = data;
    end
    count_nxt = wr_idx + (do_push ? CW'(1) : CW'(0));
  end

  // NOTE: the storage is reset (not just the count) because the head must read
  // as zero whenever the queue is empty; unused slots are kept at zero too.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_nxt;
      mem   <= mem_nxt;
    end
  end

  assign head  = mem[0];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/lpm_deserializer.sv
// Rebuilds lpm_width-bit words from an lpm_shiftreg shiftout stream, with frame
// resynchronisation and a small valid/ready output queue.
module lpm_deserializer
  import lpm_deser_pkg::*;
#(
  parameter int    lpm_width     = 8,
  parameter string lpm_direction = "LEFT",
  parameter string lpm_type      = "lpm_deserializer"
) (
  input  logic                           clock,
  input  logic                           aclr_n,
  input  logic                           sclr,
  input  logic                           shiftin,
  input  logic                           shift_en,
  input  logic                           frame,
  output logic [lpm_width-1:0]           q,
  output logic                           q_valid,
  input  logic                           q_ready,
  output logic [clog2(lpm_width)-1:0]    bit_count,
  output logic                           overrun,
  output logic                           frame_err
);

  localparam int CW       = clog2(lpm_width);
  localparam bit DIR_OK   = (lpm_direction == DIR_LEFT) || (lpm_direction == DIR_RIGHT);
  localparam bit IS_RIGHT = (lpm_direction == DIR_RIGHT);

  if (!DIR_OK) begin : g_bad_dir
    $error("%s: unsupported lpm_direction \"%s\", behaving as LEFT", lpm_type, lpm_direction);
  end

  logic [lpm_width-1:0] acc, shifted, fresh;
  logic                 word_done, push, pop, full, empty;

  // LEFT puts the first bit at the MSB end; RIGHT walks it down to the LSB.
  if (IS_RIGHT) begin : g_right
    assign shifted = {shiftin, acc[lpm_width-1:1]};
    assign fresh   = {shiftin, {(lpm_width-1){1'b0}}};
  end else begin : g_left
    assign shifted = {acc[lpm_width-2:0], shiftin};
    assign fresh   = {{(lpm_width-1){1'b0}}, shiftin};
  end

  // A frame bit always starts a new word, so it can never complete one.
  assign word_done = shift_en && !frame && (bit_count == CW'(lpm_width - 1));
  assign push      = word_done && !sclr;
  assign pop       = q_valid && q_ready && !sclr;
  assign q_valid   = !empty;

  lpm_deser_queue #(
    .WIDTH (lpm_width),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock (clock),
    .aclr_n(aclr_n),
    .clear (sclr),
    .push  (push),
    .pop   (pop),
    .data  (shifted),
    .head  (q),
    .full  (full),
    .empty (empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      acc       <= '0;
      bit_count <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (sclr) begin
      acc       <= '0;
      bit_count <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (shift_en) begin
        if (frame) begin
          acc       <= fresh;
          bit_count <= CW'(1);
          if (bit_count != '0) frame_err <= 1'b1;
        end else begin
          acc       <= shifted;
          bit_count <= word_done ? '0 : bit_count + CW'(1);
        end
      end
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lpm_deserializer.sv
// Scoreboard bench: a LEFT and a RIGHT instance share one stimulus stream and are
// checked against a bit-list reference model of word assembly and queueing.
module tb_lpm_deserializer;

  localparam int W  = 8;
  localparam int CW = 3;
  localparam int QD = 2;

  logic clock = 1'b0, aclr_n = 1'b0, sclr = 1'b0;
  logic shiftin = 1'b0, shift_en = 1'b0, frame = 1'b0, q_ready = 1'b0;

  logic [W-1:0]  q_l, q_r;
  logic          qv_l, qv_r, ov_l, ov_r, fe_l, fe_r;
  logic [CW-1:0] bc_l, bc_r;

  lpm_deserializer #(.lpm_width(W), .lpm_direction("LEFT")) dut_left (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .shiftin(shiftin),
    .shift_en(shift_en), .frame(frame), .q(q_l), .q_valid(qv_l),
    .q_ready(q_ready), .bit_count(bc_l), .overrun(ov_l), .frame_err(fe_l));

  lpm_deserializer #(.lpm_width(W), .lpm_direction("RIGHT")) dut_right (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .shiftin(shiftin),
    .shift_en(shift_en), .frame(frame), .q(q_r), .q_valid(qv_r),
    .q_ready(q_ready), .bit_count(bc_r), .overrun(ov_r), .frame_err(fe_r));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits of the partial word in arrival order, queue occupancy,
  // sticky flags, and per-direction scoreboards of words still owed by the DUT.
  bit           bits[$];
  int           occ;
  bit           m_ov, m_fe;
  logic [W-1:0] sb_l[$], sb_r[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word_of(input bit right);
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) begin
      if (right) v[i] = bits[i];
      else       v[W-1-i] = bits[i];
    end
    return v;
  endfunction

  task automatic model_reset();
    bits.delete();
    occ  = 0;
    m_ov = 1'b0;
    m_fe = 1'b0;
    sb_l.delete();
    sb_r.delete();
  endtask

  task automatic check_state();
    check("bit_count_left",  32'(bc_l), 32'(bits.size()));
    check("bit_count_right", 32'(bc_r), 32'(bits.size()));
    check("q_valid_left",    32'(qv_l), 32'(occ > 0));
    check("q_valid_right",   32'(qv_r), 32'(occ > 0));
    check("overrun_left",    32'(ov_l), 32'(m_ov));
    check("overrun_right",   32'(ov_r), 32'(m_ov));
    check("frame_err_left",  32'(fe_l), 32'(m_fe));
    check("frame_err_right", 32'(fe_r), 32'(m_fe));
    if (occ == 0) begin
      check("q_empty_left",  32'(q_l), 32'h0);
      check("q_empty_right", 32'(q_r), 32'h0);
    end
  endtask

  // Drives one cycle of inputs, predicts the effect of the coming edge, then
  // checks the DUT state one time unit after that edge.
  task automatic step(input bit se, input bit b, input bit fr, input bit rdy, input bit sc);
    bit pop, done;
    logic [W-1:0] wl, wr;
    shift_en = se; shiftin = b; frame = fr; q_ready = rdy; sclr = sc;
    done = 1'b0;
    if (!aclr_n || sc) begin
      model_reset();
    end else begin
      pop = (occ > 0) && rdy;
      if (se) begin
        if (fr) begin
          if (bits.size() != 0) m_fe = 1'b1;
          bits.delete();
          bits.push_back(b);
        end else begin
          bits.push_back(b);
          if (bits.size() == W) begin
            done = 1'b1;
            wl = word_of(1'b0);
            wr = word_of(1'b1);
            bits.delete();
          end
        end
      end
      if (pop) occ--;
      if (done) begin
        if (occ == QD) m_ov = 1'b1;
        else begin
          occ++;
          sb_l.push_back(wl);
          sb_r.push_back(wr);
        end
      end
    end
    @(posedge clock);
    #1;
    check_state();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit rdy);
    for (int i = W - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, rdy, 1'b0);
  endtask

  // Monitor: a handshake seen mid-cycle pops the DUT on the next edge.
  always @(negedge clock) begin
    if (aclr_n && !sclr && q_ready) begin
      if (qv_l) begin
        if (sb_l.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word_left: got 0x%0h, expected no word", q_l);
        end else check("q_left", 32'(q_l), 32'(sb_l.pop_front()));
      end
      if (qv_r) begin
        if (sb_r.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word_right: got 0x%0h, expected no word", q_r);
        end else check("q_right", 32'(q_r), 32'(sb_r.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_state();
    aclr_n = 1'b1;

    // Single word: LEFT sees 0xA6, RIGHT sees 0x65.
    send_word(8'hA6, 1'b1);
    idle(2, 1'b1);

    // Back-to-back words.
    send_word(8'h01, 1'b1);
    send_word(8'hFF, 1'b1);
    idle(3, 1'b1);

    // Stalled consumer: third word dropped, overrun set, then drain.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full queue with a pop on the completing edge: no overrun.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    v = 8'h44;
    for (int i = W - 1; i > 0; i--) step(1'b1, v[i], 1'b0, 1'b0, 1'b0);
    step(1'b1, v[0], 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Frame mid-word restarts the word; frame without shift_en is ignored.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    v = 8'hC3;
    step(1'b1, v[7], 1'b1, 1'b1, 1'b0);
    for (int i = W - 2; i >= 0; i--) step(1'b1, v[i], 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same word with shift_en gaps of 1-5 cycles carrying junk on shiftin.
    for (int i = W - 1; i >= 0; i--) begin
      int gap = $urandom_range(1, 5);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0);
      step(1'b1, v[i], 1'b0, 1'b1, 1'b0);
    end
    idle(2, 1'b1);

    // Async reset mid-word with one queued word and sticky flags set.
    send_word(8'h5A, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    aclr_n = 1'b0;
    #2;
    model_reset();
    check_state();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    aclr_n = 1'b1;
    idle(1, 1'b1);

    // Sync clear on a completion edge: nothing is pushed.
    send_word(8'h77, 1'b0);
    v = 8'h9C;
    for (int i = W - 1; i > 0; i--) step(1'b1, v[i], 1'b0, 1'b0, 1'b0);
    step(1'b1, v[0], 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 16) == 0),
           1'(($urandom % 3) != 0), 1'(($urandom % 200) == 0));
    end
    idle(4, 1'b1);
    check("scoreboard_drained_left",  32'(sb_l.size()), 32'h0);
    check("scoreboard_drained_right", 32'(sb_r.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
